// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared definitions for the instruction fetch stage: fetch FSM state
// encodings, the default reset PC, fault-flag bit indices, the instruction
// queue entry layout and a small alignment helper.
// ---------------------------------------------------------------------------
package ifetch_pkg;

    // First fetch address after reset (MIPS-style boot vector, sign-extended).
    localparam logic [63:0] IFETCH_RESETPC = 64'hFFFF_FFFF_BFC0_0000;

    // Bit positions inside the 2-bit fault field of a queue entry.
    localparam int EXCBUS  = 0;
    localparam int EXCADDR = 1;

    // Instruction queue depth; the pointer widths below assume exactly 4.
    localparam int IFQ_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // issuing a request or waiting for queue space
        ST_DROP  = 2'd1,   // outstanding request belongs to a flushed path
        ST_HALT  = 2'd2    // fault recorded, nothing fetched until redirect
    } fetch_state_t;

    // 98-bit queue payload.
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [1:0]  exc;
    } ifq_entry_t;

    function automatic logic is_word_aligned(input logic [63:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_ifq.sv
// ---------------------------------------------------------------------------
// ifetch_ifq
// 4-entry synchronous instruction queue. The head entry is presented
// combinationally so decode sees a word the cycle after it is written.
//
// Ports:
//   clk      in   clock
//   i_reset  in   synchronous active-high reset (clears pointers and storage)
//   i_flush  in   discard all entries; wins over a write in the same cycle
//   i_wr     in   push i_wdata at the tail
//   i_wdata  in   98-bit entry {instr, pc, exc}
//   i_rd     in   pop the head (only asserted when o_count != 0)
//   o_head   out  current head entry
//   o_count  out  number of valid entries, 0..4
// ---------------------------------------------------------------------------
module ifetch_ifq
    import ifetch_pkg::*;
(
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_flush,
    input  logic       i_wr,
    input  ifq_entry_t i_wdata,
    input  logic       i_rd,
    output ifq_entry_t o_head,
    output logic [2:0] o_count
);

    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;

    ifq_entry_t w_slot [IFQ_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < IFQ_DEPTH; gi++) begin : g_slot
            ifq_entry_t r_data;

            // Storage is cleared on reset so the head outputs read as zero.
            always_ff @(posedge clk) begin
                if (i_reset) begin
                    r_data <= '0;
                end else if (i_wr && !i_flush && (r_wr_ptr == 2'(gi))) begin
                    r_data <= i_wdata;
                end
            end

            assign w_slot[gi] = r_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (i_wr) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (i_rd) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + {2'b00, i_wr} - {2'b00, i_rd};
        end
    end

    assign o_head  = w_slot[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch
// Instruction fetch stage. Issues one outstanding word request at a time on
// the instruction memory port, queues returned words (with their PC and
// fault flags) in a 4-entry queue, and presents the queue head to decode.
// Redirects flush the queue and restart fetch; a request already on the bus
// is never withdrawn, its data is discarded instead (DROP). Bus errors and
// misaligned redirect targets produce a single faulting entry and park the
// stage in HALT until the next redirect.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   memreq    out  fetch request valid (registered)
//   memaddr   out  fetch address (registered)
//   memack    in   request accepted, memdata/memerr valid this cycle
//   memdata   in   instruction word
//   memerr    in   bus error, qualified by memack
//   rfinstr   out  queue-head instruction
//   rfpc      out  PC of rfinstr
//   rfexc     out  head fault flags: [0] bus error, [1] address error
//   rfvalid   out  queue head valid
//   rfstall   in   decode not consuming this cycle
//   redirect  in   flush and restart fetch at redirpc
//   redirpc   in   redirect target
// ---------------------------------------------------------------------------
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESETPC = IFETCH_RESETPC,
    parameter int          QDEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        memreq,
    output logic [63:0] memaddr,
    input  logic        memack,
    input  logic [31:0] memdata,
    input  logic        memerr,
    output logic [31:0] rfinstr,
    output logic [63:0] rfpc,
    output logic [1:0]  rfexc,
    output logic        rfvalid,
    input  logic        rfstall,
    input  logic        redirect,
    input  logic [63:0] redirpc
);

    localparam logic [2:0] QFULL = 3'(QDEPTH);

    fetch_state_t r_state;
    logic         r_memreq;
    logic         r_addrerr;    // misaligned target waiting to be queued
    logic [63:0]  r_fetchpc;    // address of the current/next request
    logic [63:0]  r_target;     // redirect target saved while dropping

    ifq_entry_t   w_wdata;
    ifq_entry_t   w_head;
    logic [2:0]   w_count;
    logic [2:0]   w_count_next;
    logic         w_ack;
    logic         w_deq;
    logic         w_fetch_ack;
    logic         w_addrerr_enq;
    logic         w_enq;
    logic         w_space;
    logic         w_redir_aligned;
    logic         w_target_aligned;
    logic [63:0]  w_fetchpc_inc;

    // An ack only means something while our request is on the bus; strays
    // (e.g. for a request abandoned by reset) are ignored.
    assign w_ack         = r_memreq && memack;
    assign w_deq         = (w_count != 3'd0) && !rfstall && !redirect;
    assign w_fetch_ack   = w_ack && (r_state == ST_FETCH) && !redirect;
    assign w_addrerr_enq = (r_state == ST_FETCH) && r_addrerr && !redirect;
    assign w_enq         = w_fetch_ack || w_addrerr_enq;

    always_comb begin
        w_wdata    = '0;
        w_wdata.pc = r_fetchpc;
        if (w_addrerr_enq) begin
            w_wdata.exc[EXCADDR] = 1'b1;
        end else if (memerr) begin
            w_wdata.exc[EXCBUS] = 1'b1;
        end else begin
            w_wdata.instr = memdata;
        end
    end

    // Occupancy after this edge decides whether the next request may go out,
    // which is what allows back-to-back fetch while the queue drains.
    assign w_count_next     = redirect ? 3'd0
                            : (w_count + {2'b00, w_enq} - {2'b00, w_deq});
    assign w_space          = (w_count_next < QFULL);
    assign w_fetchpc_inc    = r_fetchpc + 64'd4;
    assign w_redir_aligned  = is_word_aligned(redirpc);
    assign w_target_aligned = is_word_aligned(r_target);

    ifetch_ifq u_ifq (
        .clk     (clk),
        .i_reset (reset),
        .i_flush (redirect),
        .i_wr    (w_enq),
        .i_wdata (w_wdata),
        .i_rd    (w_deq),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_memreq  <= 1'b0;
            r_addrerr <= 1'b0;
            r_fetchpc <= RESETPC;
            r_target  <= RESETPC;
        end else if (redirect) begin
            if (r_memreq && !memack) begin
                // Request still on the bus: keep it, discard its data later.
                r_state  <= ST_DROP;
                r_target <= redirpc;
            end else begin
                r_state   <= ST_FETCH;
                r_fetchpc <= redirpc;
                r_memreq  <= w_redir_aligned;
                r_addrerr <= !w_redir_aligned;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (r_addrerr) begin
                        // Faulting entry is written this cycle.
                        r_addrerr <= 1'b0;
                        r_state   <= ST_HALT;
                    end else if (w_ack) begin
                        if (memerr) begin
                            r_memreq <= 1'b0;
                            r_state  <= ST_HALT;
                        end else begin
                            r_fetchpc <= w_fetchpc_inc;
                            r_memreq  <= w_space;
                        end
                    end else if (!r_memreq) begin
                        r_memreq <= w_space;
                    end
                end
                ST_DROP: begin
                    if (memack) begin
                        r_state   <= ST_FETCH;
                        r_fetchpc <= r_target;
                        r_memreq  <= w_target_aligned;
                        r_addrerr <= !w_target_aligned;
                    end
                end
                ST_HALT: begin
                    r_memreq <= 1'b0;
                end
                default: begin
                    r_state  <= ST_FETCH;
                    r_memreq <= 1'b0;
                end
            endcase
        end
    end

    assign memreq  = r_memreq;
    assign memaddr = r_fetchpc;
    assign rfvalid = (w_count != 3'd0);
    assign rfinstr = w_head.instr;
    assign rfpc    = w_head.pc;
    assign rfexc   = w_head.exc;

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch
// Scoreboard bench for ifetch. The stimulus process drives one cycle at a
// time and advances a behavioural model of the fetch stage; the words that
// should enter the instruction queue are pushed onto a scoreboard queue,
// and an independent monitor pops and compares them whenever decode
// consumes the head.
// ---------------------------------------------------------------------------
module tb_ifetch;

    localparam logic [63:0] RPC = 64'hFFFF_FFFF_BFC0_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [1:0]  exc;
    } exp_t;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        memack   = 1'b0;
    logic [31:0] memdata  = 32'h0;
    logic        memerr   = 1'b0;
    logic        rfstall  = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirpc  = 64'h0;
    logic        memreq;
    logic [63:0] memaddr;
    logic [31:0] rfinstr;
    logic [63:0] rfpc;
    logic [1:0]  rfexc;
    logic        rfvalid;

    ifetch #(.RESETPC(RPC), .QDEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .memreq   (memreq),
        .memaddr  (memaddr),
        .memack   (memack),
        .memdata  (memdata),
        .memerr   (memerr),
        .rfinstr  (rfinstr),
        .rfpc     (rfpc),
        .rfexc    (rfexc),
        .rfvalid  (rfvalid),
        .rfstall  (rfstall),
        .redirect (redirect),
        .redirpc  (redirpc)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_e;

    // Model of the fetch stage as seen from its ports.
    bit          m_req, m_drop, m_halt, m_aerr;
    logic [63:0] m_addr, m_target;
    // Effects of the current cycle, applied to the scoreboard at the next
    // negedge (after the monitor has popped this cycle's dequeue).
    bit          p_enq, p_flush;
    exp_t        p_entry;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_start(input logic [63:0] t);
        m_drop = 1'b0;
        m_halt = 1'b0;
        m_addr = t;
        if (t[1:0] != 2'b00) begin
            m_req  = 1'b0;
            m_aerr = 1'b1;
        end else begin
            m_req  = 1'b1;
            m_aerr = 1'b0;
        end
    endtask

    // Called at a negedge: check the request port, drive this cycle's
    // inputs, predict the next cycle, then wait for the next negedge.
    task automatic step(input bit ack, input bit err, input bit stall,
                        input bit redir, input logic [63:0] rpc);
        int sz;
        bit acc, deq;
        if (p_flush) q.delete();
        if (p_enq) q.push_back(p_entry);
        p_flush = 1'b0;
        p_enq   = 1'b0;

        check("memreq", 64'(memreq), 64'(m_req));
        if (m_req) check("memaddr", memaddr, m_addr);

        memack   = ack;
        memerr   = ack ? err : 1'b0;
        memdata  = mem_word(memaddr);
        rfstall  = stall;
        redirect = redir;
        redirpc  = rpc;

        sz  = q.size();
        acc = m_req && ack;
        deq = (sz != 0) && !stall && !redir;

        if (redir) begin
            p_flush = 1'b1;
            if (m_req && !ack) begin
                m_drop   = 1'b1;
                m_target = rpc;
            end else begin
                model_start(rpc);
            end
        end else if (m_drop) begin
            if (ack) model_start(m_target);
        end else if (m_aerr) begin
            p_enq   = 1'b1;
            p_entry = {32'h0, m_addr, 2'b10};
            m_aerr  = 1'b0;
            m_halt  = 1'b1;
        end else if (!m_halt) begin
            if (acc) begin
                p_enq = 1'b1;
                if (err) begin
                    p_entry = {32'h0, m_addr, 2'b01};
                    m_req   = 1'b0;
                    m_halt  = 1'b1;
                end else begin
                    p_entry = {mem_word(m_addr), m_addr, 2'b00};
                    m_addr  = m_addr + 64'd4;
                    m_req   = (sz + 1 - int'(deq)) < 4;
                end
            end else if (!m_req) begin
                m_req = (sz - int'(deq)) < 4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n, input bit stray);
        reset    = 1'b1;
        memack   = stray;
        memerr   = 1'b0;
        rfstall  = 1'b0;
        redirect = 1'b0;
        q.delete();
        p_enq  = 1'b0;
        p_flush = 1'b0;
        m_req  = 1'b0;
        m_drop = 1'b0;
        m_halt = 1'b0;
        m_aerr = 1'b0;
        m_addr = RPC;
        m_target = RPC;
        repeat (n) begin
            @(negedge clk);
            check("rst_memreq", 64'(memreq), 64'd0);
            check("rst_memaddr", memaddr, RPC);
            check("rst_rfvalid", 64'(rfvalid), 64'd0);
            check("rst_rfinstr", 64'(rfinstr), 64'd0);
            check("rst_rfpc", rfpc, 64'd0);
            check("rst_rfexc", 64'(rfexc), 64'd0);
        end
        reset = 1'b0;
    endtask

    // Monitor: compares the queue head whenever decode consumes it.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            check("rfvalid", 64'(rfvalid), 64'(q.size() != 0));
            if (q.size() != 0 && !rfstall && !redirect) begin
                mon_e = q.pop_front();
                check("rfinstr", 64'(rfinstr), 64'(mon_e.instr));
                check("rfpc", rfpc, mon_e.pc);
                check("rfexc", 64'(rfexc), 64'(mon_e.exc));
            end
        end
    end

    task automatic random_cycles(input int n, input int stall_pct);
        for (int i = 0; i < n; i++) begin
            bit          a, e, s, r;
            logic [63:0] t;
            a = memreq ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 5);
            e = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < stall_pct);
            r = ($urandom_range(0, 99) < 3);
            case ($urandom_range(0, 5))
                0: begin
                    t = {32'hFFFF_FFFF, $urandom()};
                    t[1:0] = 2'($urandom_range(1, 3));
                end
                1: t = 64'hFFFF_FFFF_FFFF_FFF8;
                default: begin
                    t = {$urandom(), $urandom()};
                    t[1:0] = 2'b00;
                end
            endcase
            step(a, e, s, r, t);
        end
    endtask

    initial begin
        @(negedge clk);
        // Reset release, ack every cycle: sequential fetch at 1 word/cycle.
        do_reset(3, 1'b0);
        repeat (12) step(1, 0, 0, 0, 64'h0);

        // Decode stalled: queue fills to 4, requests stop, resume on dequeue.
        repeat (10) step(1, 0, 1, 0, 64'h0);
        repeat (6) step(1, 0, 0, 0, 64'h0);

        // Redirect while a request waits for its ack: DROP path.
        step(0, 0, 0, 0, 64'h0);
        step(0, 0, 0, 1, 64'h0000_0000_8000_1000);
        repeat (2) step(0, 0, 0, 0, 64'h0);
        repeat (5) step(1, 0, 0, 0, 64'h0);

        // Redirect together with ack and a possible dequeue.
        repeat (2) step(1, 0, 1, 0, 64'h0);
        step(1, 0, 0, 1, 64'h0000_0000_8000_2000);
        repeat (3) step(1, 0, 0, 0, 64'h0);

        // Bus error on the third fetch after reset, then stray acks in HALT.
        do_reset(2, 1'b0);
        step(0, 0, 0, 0, 64'h0);
        step(1, 0, 0, 0, 64'h0);
        step(1, 0, 0, 0, 64'h0);
        step(1, 1, 0, 0, 64'h0);
        repeat (4) step(0, 0, 0, 0, 64'h0);
        repeat (2) step(1, 0, 0, 0, 64'h0);

        // Misaligned redirect: one address-fault entry, no request, HALT.
        step(0, 0, 1, 1, 64'h0000_0000_8000_0002);
        repeat (3) step(0, 0, 1, 0, 64'h0);
        repeat (3) step(0, 0, 0, 0, 64'h0);
        step(0, 0, 0, 1, 64'h0000_0000_8000_3000);

        // Wrap of the 64-bit fetch address.
        step(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (6) step(1, 0, 0, 0, 64'h0);

        random_cycles(1500, 25);
        // Reset in the middle of traffic, with a stray ack afterwards.
        do_reset(2, 1'b1);
        step(1, 0, 0, 0, 64'h0);
        random_cycles(1500, 65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
